ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 13 +
 rtl/div_iter.sv | 56 +++++
 rtl/ex_stage.sv | 79 +++++++
 tb/tb_ex_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, stall encoding and divider state encodings for the EX stage
package ex_stage_pkg;
  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 141;
  localparam int EX_TO_RF_WD  = 38;
  localparam int StallBus     = 6;
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  typedef enum logic [1:0] {DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_DONE = 2'd2} div_state_e;
  function automatic logic [31:0] neg_if(input logic [31:0] x, input logic n);
    return n ? -x : x;
  endfunction
endpackage

// File: rtl/div_iter.sv
// div_iter: iterative 32-bit restoring divider (signed/unsigned) with IDLE/BUSY/DONE control
module div_iter import ex_stage_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        adv_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  div_state_e state_q, state_d;
  logic [4:0] cnt_q;
  logic [31:0] r_q, q_q, d_q;
  logic negq_q, negr_q, dz, go, ge;
  logic [32:0] rs;
  assign dz = b_i == '0;
  assign go = state_q == DIV_IDLE && start_i;
  assign rs = {r_q, q_q[31]};
  assign ge = rs >= {1'b0, d_q};
  always_ff @(posedge clk) state_q <= rst ? DIV_IDLE : state_d;
  always_comb
    state_d = state_q == DIV_IDLE ? (start_i ? (dz ? DIV_DONE : DIV_BUSY) : DIV_IDLE) :
              state_q == DIV_BUSY ? (cnt_q == 5'd31 ? DIV_DONE : DIV_BUSY) :
              (adv_i ? DIV_IDLE : DIV_DONE);
  always_comb begin
    busy_o = go || state_q == DIV_BUSY;
    done_o = state_q == DIV_DONE;
    hi_o   = neg_if(r_q, negr_q);
    lo_o   = neg_if(q_q, negq_q);
  end
  // divide-by-zero preloads the architectural result so DONE needs no special case
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (go) begin
      cnt_q  <= '0;
      r_q    <= dz ? a_i : '0;
      q_q    <= dz ? '1 : neg_if(a_i, signed_i & a_i[31]);
      d_q    <= neg_if(b_i, signed_i & b_i[31]);
      negq_q <= ~dz & signed_i & (a_i[31] ^ b_i[31]);
      negr_q <= ~dz & signed_i & a_i[31];
    end else if (state_q == DIV_BUSY) begin
      cnt_q <= cnt_q + 5'd1;
      r_q   <= ge ? rs[31:0] - d_q : rs[31:0];
      q_q   <= {q_q[30:0], ge};
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: EX pipeline stage (input register, ALU, data SRAM request, forwarding)
// Optional iterative divider enabled with `define EX_DIV_EN
module ex_stage import ex_stage_pkg::*; (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);
  logic [ID_TO_EX_WD-1:0] ex_q, ex_d;
  logic [31:0] pc, inst, data1, data2, src1, src2, imm_s, sra_r, ex_result, hi, lo;
  logic [11:0] op;
  logic [2:0] s1;
  logic [3:0] s2, ram_wen;
  logic [4:0] rf_waddr;
  logic ram_en, rf_we, sel_rf_res, hilo_we, unused;
  always_comb
    ex_d = (stall[2] == Stop && stall[3] == NoStop) ? '0 : stall[2] == NoStop ? id_to_ex_bus : ex_q;
  always_ff @(posedge clk) ex_q <= rst ? '0 : ex_d;
  assign {pc, inst, op, s1, s2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res, data1, data2} = ex_q;
  assign imm_s = {{16{inst[15]}}, inst[15:0]};
  assign sra_r = $signed(src2) >>> src1[4:0];
  always_comb begin
    src1 = s1[0] ? data1 : s1[1] ? pc : s1[2] ? {27'd0, inst[10:6]} : '0;
    src2 = s2[0] ? data2 : s2[1] ? imm_s : s2[2] ? 32'd8 : s2[3] ? {16'd0, inst[15:0]} : '0;
    ex_result = ({32{op[11]}} & (src1 + src2))
              | ({32{op[10]}} & (src1 - src2))
              | ({32{op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
              | ({32{op[8]}}  & {31'd0, src1 < src2})
              | ({32{op[7]}}  & (src1 & src2))
              | ({32{op[6]}}  & ~(src1 | src2))
              | ({32{op[5]}}  & (src1 | src2))
              | ({32{op[4]}}  & (src1 ^ src2))
              | ({32{op[3]}}  & (src2 << src1[4:0]))
              | ({32{op[2]}}  & (src2 >> src1[4:0]))
              | ({32{op[1]}}  & sra_r)
              | ({32{op[0]}}  & {inst[15:0], 16'd0});
  end
`ifdef EX_DIV_EN
  logic is_div, dv_busy, dv_done;
  logic [31:0] dv_hi, dv_lo;
  assign is_div = inst[31:26] == 6'd0 && inst[5:1] == 5'b01101;
  div_iter u_div (
    .clk,
    .rst,
    .start_i (is_div),
    .signed_i(~inst[0]),
    .adv_i   (stall[2] == NoStop),
    .a_i     (data1),
    .b_i     (data2),
    .busy_o  (dv_busy),
    .done_o  (dv_done),
    .hi_o    (dv_hi),
    .lo_o    (dv_lo)
  );
  assign stallreq_for_ex = dv_busy;
  assign hilo_we = dv_done & is_div;
  assign hi = hilo_we ? dv_hi : '0;
  assign lo = hilo_we ? dv_lo : '0;
`else
  assign stallreq_for_ex = 1'b0;
  assign hilo_we = 1'b0;
  assign hi = '0;
  assign lo = '0;
`endif
  assign unused = ^{stall[5:4], stall[1:0], inst};
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = data1 + imm_s;
  assign data_sram_wdata = data2;
  assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};
  assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result, hilo_we, hi, lo};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for ex_stage checked against a cycle-level reference model
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  logic [5:0] stall;
  logic [158:0] id;
  logic [140:0] ex_to_mem_bus;
  logic [37:0] ex_to_rf_bus;
  logic data_sram_en, stallreq_for_ex;
  logic [3:0] data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  int tests = 0, fails = 0;
  bit auto_stall = 1'b0;
`ifdef EX_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam logic [11:0] ADD = 12'h800, SUB = 12'h400, SLT = 12'h200, SLTU = 12'h100,
    AND = 12'h080, NOR = 12'h040, OR = 12'h020, XOR = 12'h010, SLL = 12'h008,
    SRL = 12'h004, SRA = 12'h002, LUI = 12'h001;

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_to_ex_bus   (id),
    .ex_to_mem_bus  (ex_to_mem_bus),
    .ex_to_rf_bus   (ex_to_rf_bus),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .stallreq_for_ex(stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic re, input logic [3:0] rw,
      input logic we, input logic [4:0] wa, input logic sel, input logic [31:0] d1, d2);
    return {pc, inst, op, s1, s2, re, rw, we, wa, sel, d1, d2};
  endfunction

  // reference: what the stage must present given the instruction it holds and how long it has held it
  function automatic void model(input logic [158:0] m, input int c, output logic [140:0] mem, output logic sreq);
    logic [31:0] pc, inst, d1, d2, a, b, r, hi, lo;
    logic [11:0] op;
    logic [2:0] s1;
    logic [3:0] s2;
    logic isdiv, we;
    int need;
    {pc, inst, op, s1, s2} = m[158:76];
    d1 = m[63:32];
    d2 = m[31:0];
    a = s1[0] ? d1 : s1[1] ? pc : s1[2] ? {27'd0, inst[10:6]} : 32'd0;
    b = s2[0] ? d2 : s2[1] ? {{16{inst[15]}}, inst[15:0]} : s2[2] ? 32'd8 : s2[3] ? {16'd0, inst[15:0]} : 32'd0;
    r = 0;
    if (op[11]) r = a + b;
    if (op[10]) r = a - b;
    if (op[9]) r = ($signed(a) < $signed(b)) ? 1 : 0;
    if (op[8]) r = (a < b) ? 1 : 0;
    if (op[7]) r = a & b;
    if (op[6]) r = ~(a | b);
    if (op[5]) r = a | b;
    if (op[4]) r = a ^ b;
    if (op[3]) r = b << a[4:0];
    if (op[2]) r = b >> a[4:0];
    if (op[1]) r = $signed(b) >>> a[4:0];
    if (op[0]) r = {inst[15:0], 16'h0};
    isdiv = DIV_ON && inst[31:26] == 0 && (inst[5:0] == 6'h1A || inst[5:0] == 6'h1B);
    need = (d2 == 0) ? 1 : 33;
    sreq = isdiv && c < need;
    we = isdiv && c >= need;
    hi = 0;
    lo = 0;
    if (we) begin
      if (d2 == 0) begin
        lo = 32'hFFFFFFFF;
        hi = d1;
      end else if (inst[0]) begin
        lo = d1 / d2;
        hi = d1 % d2;
      end else begin
        lo = $signed(d1) / $signed(d2);
        hi = $signed(d1) % $signed(d2);
      end
    end
    mem = {pc, m[75], m[74:71], m[64], m[70], m[69:65], r, we, hi, lo};
  endfunction

  logic [158:0] mreg;
  int mcyc;
  bit mvalid = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      mreg = '0;
      mcyc = 0;
      mvalid = 1'b1;
    end else if (stall[2] && !stall[3]) begin
      mreg = '0;
      mcyc = 0;
    end else if (!stall[2]) begin
      mreg = id;
      mcyc = 0;
    end else mcyc++;
  end

  logic [140:0] e_mem;
  logic e_sreq;
  always @(negedge clk) if (mvalid) begin
    model(mreg, mcyc, e_mem, e_sreq);
    chk("m_mem", ex_to_mem_bus, e_mem);
    chk("m_rf", ex_to_rf_bus, e_mem[102:65]);
    chk("m_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
        {mreg[75], mreg[74:71], mreg[63:32] + {{16{mreg[110]}}, mreg[110:95]}, mreg[31:0]});
    chk("m_stall", stallreq_for_ex, e_sreq);
  end

  // a stall controller that freezes IF..MEM whenever EX asks
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_stall) stall = stallreq_for_ex ? 6'b001111 : 6'b000000;
    @(negedge clk);
  endtask

  task automatic run_div(input string nm, input logic [31:0] inst, d1, d2, input int es, input logic [31:0] ehi, elo);
    int n = 0;
    id = mk(32'h100, inst, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, d1, d2);
    cyc();
    id = '0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      cyc();
    end
    chk({nm, "_stalls"}, n, es);
    chk({nm, "_hilo"}, ex_to_mem_bus[64:0], {DIV_ON, ehi, elo});
    cyc();
    chk({nm, "_after"}, ex_to_mem_bus[64], 1'b0);
  endtask

  logic [158:0] vec[16];
  logic [31:0] exp_r[16];
  initial begin
    vec[0]  = mk(32'h0, 32'h2423FFFF, ADD, 3'b001, 4'b0010, 0, 0, 1, 3, 0, 5, 0);                 exp_r[0]  = 32'h4;
    vec[1]  = mk(32'hBFC00010, 32'h0C000000, ADD, 3'b010, 4'b0100, 0, 0, 1, 31, 0, 0, 0);         exp_r[1]  = 32'hBFC00018;
    vec[2]  = mk(32'h4, 32'h0, SUB, 3'b001, 4'b0001, 0, 0, 1, 4, 0, 3, 5);                         exp_r[2]  = 32'hFFFFFFFE;
    vec[3]  = mk(32'h8, 32'h0, SLT, 3'b001, 4'b0001, 0, 0, 1, 5, 0, 32'hFFFFFFFF, 1);              exp_r[3]  = 32'h1;
    vec[4]  = mk(32'hC, 32'h0, SLTU, 3'b001, 4'b0001, 0, 0, 1, 6, 0, 32'hFFFFFFFF, 1);             exp_r[4]  = 32'h0;
    vec[5]  = mk(32'h10, 32'h0, AND, 3'b001, 4'b0001, 0, 0, 1, 7, 0, 32'hF0F0F0F0, 32'hFF00FF00);  exp_r[5]  = 32'hF000F000;
    vec[6]  = mk(32'h14, 32'h0, NOR, 3'b001, 4'b0001, 0, 0, 1, 8, 0, 32'hF0F0F0F0, 32'h0F0F0000);  exp_r[6]  = 32'h00000F0F;
    vec[7]  = mk(32'h18, 32'h0, OR, 3'b001, 4'b0001, 0, 0, 1, 9, 0, 32'h12340000, 32'h00005678);   exp_r[7]  = 32'h12345678;
    vec[8]  = mk(32'h1C, 32'h0, XOR, 3'b001, 4'b0001, 0, 0, 1, 10, 0, 32'hFFFF0000, 32'h0F0F0F0F); exp_r[8]  = 32'hF0F00F0F;
    vec[9]  = mk(32'h20, 32'h100, SLL, 3'b100, 4'b0001, 0, 0, 1, 11, 0, 0, 32'hF);                 exp_r[9]  = 32'hF0;
    vec[10] = mk(32'h24, 32'h100, SRL, 3'b100, 4'b0001, 0, 0, 1, 12, 0, 0, 32'h80000000);          exp_r[10] = 32'h08000000;
    vec[11] = mk(32'h28, 32'h100, SRA, 3'b100, 4'b0001, 0, 0, 1, 13, 0, 0, 32'h80000000);          exp_r[11] = 32'hF8000000;
    vec[12] = mk(32'h2C, 32'h3C011234, LUI, 3'b000, 4'b0000, 0, 0, 1, 1, 0, 0, 0);                 exp_r[12] = 32'h12340000;
    vec[13] = mk(32'h30, 32'h34018000, OR, 3'b001, 4'b1000, 0, 0, 1, 1, 0, 1, 0);                  exp_r[13] = 32'h00008001;
    vec[14] = mk(32'h34, 32'hAC22FFFC, ADD, 3'b001, 4'b0010, 1, 4'hF, 0, 0, 0, 32'h1000, 32'hDEADBEEF); exp_r[14] = 32'h00000FFC;
    vec[15] = mk(32'h38, 32'h0, SLL, 3'b001, 4'b0001, 0, 0, 1, 14, 0, 36, 1);                      exp_r[15] = 32'h10;
    rst = 1'b1;
    stall = '0;
    id = '0;
    cyc();
    cyc();
    chk("rst_rf", ex_to_rf_bus, 38'd0);
    chk("rst_mem", ex_to_mem_bus, 141'd0);
    chk("rst_stallreq", stallreq_for_ex, 1'b0);
    chk("rst_sram", {data_sram_en, data_sram_wen}, 5'd0);
    rst = 1'b0;
    auto_stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id = vec[i];
      cyc();
      chk($sformatf("alu%0d", i), ex_to_rf_bus[31:0], exp_r[i]);
      if (i == 0) chk("addiu_rf", ex_to_rf_bus, {1'b1, 5'd3, 32'd4});
      if (i == 14) chk("sw_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                       {1'b1, 4'hF, 32'h00000FFC, 32'hDEADBEEF});
    end
    run_div("divu", 32'h0022001B, 32'd100, 32'd7, DIV_ON ? 33 : 0, DIV_ON ? 32'd2 : 32'd0, DIV_ON ? 32'd14 : 32'd0);
    run_div("div_neg", 32'h0022001A, 32'hFFFFFFF9, 32'd2, DIV_ON ? 33 : 0,
            DIV_ON ? 32'hFFFFFFFF : 32'd0, DIV_ON ? 32'hFFFFFFFD : 32'd0);
    run_div("div_zero", 32'h0022001A, 32'd5, 32'd0, DIV_ON ? 1 : 0, DIV_ON ? 32'd5 : 32'd0, DIV_ON ? 32'hFFFFFFFF : 32'd0);
    auto_stall = 1'b0;
    stall = 6'b000000;
    id = vec[13];
    cyc();
    stall = 6'b001111;
    id = vec[12];
    cyc();
    chk("hold", ex_to_rf_bus[31:0], 32'h00008001);
    stall = 6'b000111;
    cyc();
    chk("bubble", ex_to_mem_bus, 141'd0);
    stall = 6'b000000;
    auto_stall = 1'b1;
    id = mk(32'h100, 32'h0022001B, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'd100, 32'd7);
    cyc();
    id = '0;
    repeat (11) cyc();
    chk("busy_cnt10", stallreq_for_ex, DIV_ON);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_stallreq", stallreq_for_ex, 1'b0);
    chk("rst_mid_mem", ex_to_mem_bus, 141'd0);
    chk("rst_mid_rf", ex_to_rf_bus, 38'd0);
    repeat (3) cyc();
    chk("idle_after_rst", stallreq_for_ex, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
